// File: rtl/act_pwl_unit_pkg.sv
// act_pwl_unit_pkg: shared definitions for the piecewise-linear activation unit.
// Holds the default number formats, the LUT entry layout, the table-select and
// LUT address widths, and the saturation limits for the default Q_SIZE.
// Optional feature macro used elsewhere in this slice: ACT_PWL_SAT_CNT_EN.
package act_pwl_unit_pkg;

  localparam int unsigned LANES_DEF      = 4;
  localparam int unsigned Q_INT_DEF      = 4;
  localparam int unsigned Q_FRAC_DEF     = 12;
  localparam int unsigned Q_SIZE_DEF     = Q_INT_DEF + Q_FRAC_DEF;
  localparam int unsigned LUT_DEPTH_DEF  = 6;
  localparam int unsigned FUNC_COUNT_DEF = 4;
  localparam int unsigned A_INT_DEF      = 4;
  localparam int unsigned A_FRAC_DEF     = 12;
  localparam int unsigned B_INT_DEF      = 4;
  localparam int unsigned B_FRAC_DEF     = 12;

  // Table-select width: clog2 of the table count, never below one bit.
  function automatic int unsigned fsel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned FSEL_W     = fsel_width(FUNC_COUNT_DEF);
  localparam int unsigned LUT_ADDR_W = FSEL_W + LUT_DEPTH_DEF;

  localparam logic signed [Q_SIZE_DEF-1:0] SAT_MAX = {1'b0, {(Q_SIZE_DEF-1){1'b1}}};
  localparam logic signed [Q_SIZE_DEF-1:0] SAT_MIN = {1'b1, {(Q_SIZE_DEF-1){1'b0}}};

  // One coefficient word; the slope sits in the upper field.
  typedef struct packed {
    logic signed [A_INT_DEF+A_FRAC_DEF-1:0] a;
    logic signed [B_INT_DEF+B_FRAC_DEF-1:0] b;
  } lut_entry_t;

endpackage

// File: rtl/act_pwl_unit_if.sv
// act_pwl_unit_if: valid/ready stream bundle for the activation unit.
//   in_valid/in_ready/in_data/in_func/in_bypass : input beat (x per lane)
//   out_valid/out_ready/out_data                : result beat (y per lane)
// master = producer/consumer side (bench or upstream), slave = the unit.
interface act_pwl_unit_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned Q_SIZE = 16,
  parameter int unsigned FSEL_W = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*Q_SIZE-1:0]   in_data;
  logic [FSEL_W-1:0]         in_func;
  logic [LANES-1:0]          in_bypass;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*Q_SIZE-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_func, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_func, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/act_pwl_unit_lane.sv
// act_pwl_lane: one lane of the activation unit.
// Holds a private synchronous-read copy of the coefficient LUT (writes are
// broadcast by the top) and the S0 read / S1 multiply / S2 add+saturate pipe.
//   clk, rst        : clock, async active-high reset
//   adv             : global pipeline advance
//   lut_we/waddr/wdata : coefficient write port {A, B}
//   rd_addr, x, bypass : beat entering S0
//   y               : registered lane result
//   sat             : lane saturated (only with ACT_PWL_SAT_CNT_EN)
module act_pwl_lane
  import act_pwl_unit_pkg::*;
#(
  parameter int unsigned Q_INT     = Q_INT_DEF,
  parameter int unsigned Q_FRAC    = Q_FRAC_DEF,
  parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int unsigned FSEL_W    = 2,
  parameter int unsigned A_INT     = A_INT_DEF,
  parameter int unsigned A_FRAC    = A_FRAC_DEF,
  parameter int unsigned B_INT     = B_INT_DEF,
  parameter int unsigned B_FRAC    = B_FRAC_DEF,
  localparam int unsigned QS   = Q_INT + Q_FRAC,
  localparam int unsigned AD_W = FSEL_W + LUT_DEPTH,
  localparam int unsigned AW   = A_INT + A_FRAC,
  localparam int unsigned BW   = B_INT + B_FRAC,
  localparam int unsigned CW   = AW + BW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 lut_we,
  input  logic [AD_W-1:0]      lut_waddr,
  input  logic [CW-1:0]        lut_wdata,
  input  logic [AD_W-1:0]      rd_addr,
  input  logic signed [QS-1:0] x,
  input  logic                 bypass,
  output logic signed [QS-1:0] y
`ifdef ACT_PWL_SAT_CNT_EN
  ,
  output logic                 sat
`endif
);

  localparam int unsigned PW  = AW + QS;
  localparam int unsigned BSH = Q_FRAC - B_FRAC;
  localparam int unsigned SW  = ((PW > BW + BSH) ? PW : BW + BSH) + 2;
  localparam logic signed [QS-1:0] QMAX = {1'b0, {(QS-1){1'b1}}};
  localparam logic signed [QS-1:0] QMIN = {1'b1, {(QS-1){1'b0}}};

  logic [CW-1:0] mem [2**AD_W];
  logic [CW-1:0] rd_word;

  logic signed [AW-1:0] s0_a;
  logic signed [BW-1:0] s0_b;
  logic signed [QS-1:0] s0_x;
  logic                 s0_byp;
  logic signed [PW-1:0] s1_prod;
  logic signed [BW-1:0] s1_b;
  logic signed [QS-1:0] s1_x;
  logic                 s1_byp;

  logic signed [PW-1:0] shifted;
  logic signed [SW-1:0] sum;
  logic                 ovf_hi;
  logic                 ovf_lo;
  logic signed [QS-1:0] sat_val;

  // LUT storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (lut_we) mem[lut_waddr] <= lut_wdata;
  end

  // Non-blocking write above makes a same-cycle read return the old word.
  assign rd_word = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_a    <= '0;
      s0_b    <= '0;
      s0_x    <= '0;
      s0_byp  <= 1'b0;
      s1_prod <= '0;
      s1_b    <= '0;
      s1_x    <= '0;
      s1_byp  <= 1'b0;
      y       <= '0;
    end else if (adv) begin
      s0_a    <= rd_word[CW-1 -: AW];
      s0_b    <= rd_word[BW-1:0];
      s0_x    <= x;
      s0_byp  <= bypass;
      s1_prod <= PW'(s0_a) * PW'(s0_x);
      s1_b    <= s0_b;
      s1_x    <= s0_x;
      s1_byp  <= s0_byp;
      y       <= s1_byp ? s1_x : sat_val;
    end
  end

  always_comb begin
    shifted = s1_prod >>> A_FRAC;
    sum     = SW'(shifted) + (SW'(s1_b) <<< BSH);
    ovf_hi  = sum > SW'(QMAX);
    ovf_lo  = sum < SW'(QMIN);
    if (ovf_hi)      sat_val = QMAX;
    else if (ovf_lo) sat_val = QMIN;
    else             sat_val = sum[QS-1:0];
  end

`ifdef ACT_PWL_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sat <= 1'b0;
    else if (adv) sat <= !s1_byp && (ovf_hi || ovf_lo);
  end
`endif

endmodule

// File: rtl/act_pwl_unit.sv
// act_pwl_unit: multi-lane piecewise-linear activation, y = A[seg]*x + B[seg].
//   clk, rst  : clock, async active-high reset
//   bus       : act_pwl_unit_if.slave stream (in beat -> out beat, 3-cycle pipe)
//   lut_we/lut_waddr/lut_wdata : coefficient write, address {func, seg}, data {A, B}
//   sat_clr/sat_count : saturation event counter (only with ACT_PWL_SAT_CNT_EN)
// The whole pipe advances together; in_ready is the combinational advance.
module act_pwl_unit
  import act_pwl_unit_pkg::*;
#(
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned Q_INT      = Q_INT_DEF,
  parameter int unsigned Q_FRAC     = Q_FRAC_DEF,
  parameter int unsigned LUT_DEPTH  = LUT_DEPTH_DEF,
  parameter int unsigned FUNC_COUNT = FUNC_COUNT_DEF,
  parameter int unsigned A_INT      = A_INT_DEF,
  parameter int unsigned A_FRAC     = A_FRAC_DEF,
  parameter int unsigned B_INT      = B_INT_DEF,
  parameter int unsigned B_FRAC     = B_FRAC_DEF,
  localparam int unsigned Q_SIZE = Q_INT + Q_FRAC,
  localparam int unsigned FS_W   = fsel_width(FUNC_COUNT),
  localparam int unsigned AD_W   = FS_W + LUT_DEPTH,
  localparam int unsigned CW     = A_INT + A_FRAC + B_INT + B_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  act_pwl_unit_if.slave    bus,
  input  logic             lut_we,
  input  logic [AD_W-1:0]  lut_waddr,
  input  logic [CW-1:0]    lut_wdata
`ifdef ACT_PWL_SAT_CNT_EN
  ,
  input  logic             sat_clr,
  output logic [31:0]      sat_count
`endif
);

  logic                        advance;
  logic                        v0;
  logic                        v1;
  logic                        out_valid_q;
  logic signed [Q_SIZE-1:0]    y_lane [LANES];
  logic [LANES*Q_SIZE-1:0]     out_data_w;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      v0          <= bus.in_valid;
      v1          <= v0;
      out_valid_q <= v1;
    end
  end

`ifdef ACT_PWL_SAT_CNT_EN
  logic [LANES-1:0] sat_lane;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [Q_SIZE-1:0] x;
    logic [LUT_DEPTH-1:0]     seg;
    assign x   = bus.in_data[i*Q_SIZE +: Q_SIZE];
    // Offset-binary segment: inverting the sign makes segment 0 the most negative.
    assign seg = {~x[Q_SIZE-1], x[Q_SIZE-2 -: LUT_DEPTH-1]};

    act_pwl_lane #(
      .Q_INT(Q_INT), .Q_FRAC(Q_FRAC), .LUT_DEPTH(LUT_DEPTH), .FSEL_W(FS_W),
      .A_INT(A_INT), .A_FRAC(A_FRAC), .B_INT(B_INT), .B_FRAC(B_FRAC)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .adv       (advance),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .rd_addr   ({bus.in_func, seg}),
      .x         (x),
      .bypass    (bus.in_bypass[i]),
      .y         (y_lane[i])
`ifdef ACT_PWL_SAT_CNT_EN
      ,
      .sat       (sat_lane[i])
`endif
    );
  end

  always_comb begin
    out_data_w = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_data_w[i*Q_SIZE +: Q_SIZE] = y_lane[i];
    end
  end
  assign bus.out_data = out_data_w;

`ifdef ACT_PWL_SAT_CNT_EN
  logic [31:0] nsat;
  logic [32:0] sat_sum;

  always_comb begin
    nsat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      nsat = nsat + 32'(sat_lane[i]);
    end
    sat_sum = {1'b0, sat_count} + {1'b0, nsat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             sat_count <= '0;
    else if (sat_clr)                    sat_count <= '0;
    else if (out_valid_q && bus.out_ready) sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_act_pwl_unit.sv
// tb_act_pwl_unit: directed, table-driven bench for act_pwl_unit (4 lanes, Q4.12).
// Build with ACT_PWL_SAT_CNT_EN defined to also exercise the saturation counter.
module tb_act_pwl_unit;
  import act_pwl_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lut_we;
  logic [7:0]  lut_waddr;
  logic [31:0] lut_wdata;
`ifdef ACT_PWL_SAT_CNT_EN
  logic        sat_clr;
  logic [31:0] sat_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_pwl_unit_if #(.LANES(4), .Q_SIZE(16), .FSEL_W(2)) bus ();

  act_pwl_unit #(
    .LANES(4), .Q_INT(4), .Q_FRAC(12), .LUT_DEPTH(6), .FUNC_COUNT(4),
    .A_INT(4), .A_FRAC(12), .B_INT(4), .B_FRAC(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata)
`ifdef ACT_PWL_SAT_CNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
`endif
  );

  typedef struct {
    logic [1:0]  func;
    logic [3:0]  byp;
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input logic [1:0] func, input logic [5:0] seg,
                           input logic [15:0] a, input logic [15:0] b);
    lut_entry_t e;
    e.a = a;
    e.b = b;
    lut_we    = 1'b1;
    lut_waddr = {func, seg};
    lut_wdata = e;
    step();
    lut_we = 1'b0;
  endtask

  task automatic load_table(input logic [1:0] func, input logic [15:0] a, input logic [15:0] b);
    for (int s = 0; s < 64; s++) lut_write(func, 6'(s), a, b);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  // Present one beat, then report the result and the cycles to out_valid.
  task automatic run_one(input logic [1:0] func, input logic [3:0] byp, input logic [63:0] x,
                         output logic [63:0] y, output int lat);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_func   = func;
    bus.in_bypass = byp;
    bus.in_data   = x;
    step();
    bus.in_valid = 1'b0;
    wait_valid(n);
    lat = n + 1;
    y   = bus.out_data;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] y;
    int          lat;
    int          n;

    vecs[0] = '{2'd0, 4'b0000, 64'h1800_1800_1800_1800, 64'h1800_1800_1800_1800};
    vecs[1] = '{2'd0, 4'b0000, 64'h7FFF_8000_F000_0001, 64'h7FFF_8000_F000_0001};
    vecs[2] = '{2'd2, 4'b0000, 64'h7000_7000_7000_7000, 64'h7FFF_7FFF_7FFF_7FFF};
    vecs[3] = '{2'd2, 4'b0000, 64'h9000_9000_9000_9000, 64'h8000_8000_8000_8000};
    vecs[4] = '{2'd2, 4'b0000, 64'h2000_1FFF_E000_1000, 64'h7FFF_7FFC_8000_4000};
    vecs[5] = '{2'd1, 4'b0101, 64'h2000_2000_2000_2000, 64'h0800_2000_0800_2000};
    vecs[6] = '{2'd3, 4'b0000, 64'h8000_1000_FFFF_0001, 64'hB800_0000_F7FF_F800};
    vecs[7] = '{2'd2, 4'b0011, 64'h7000_7000_7000_7000, 64'h7FFF_7FFF_7000_7000};
    vecs[8] = '{2'd1, 4'b1111, 64'h1234_8000_7FFF_0000, 64'h1234_8000_7FFF_0000};

    rst           = 1'b1;
    lut_we        = 1'b0;
    lut_waddr     = '0;
    lut_wdata     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_func   = '0;
    bus.in_bypass = '0;
    bus.out_ready = 1'b1;
`ifdef ACT_PWL_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    step();
    step();
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    step();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ACT_PWL_SAT_CNT_EN
    chk("reset_sat_count", 64'(sat_count), 64'd0);
`endif

    load_table(2'd0, 16'h1000, 16'h0000);  // identity
    load_table(2'd1, 16'h0000, 16'h0800);  // constant 0.5
    load_table(2'd2, 16'h4000, 16'h0000);  // 4x, saturates
    load_table(2'd3, 16'h0800, 16'hF800);  // 0.5x - 0.5, exercises floor

    for (int i = 0; i < NV; i++) begin
      run_one(vecs[i].func, vecs[i].byp, vecs[i].x, y, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_data", i), y, vecs[i].y);
    end

`ifdef ACT_PWL_SAT_CNT_EN
    // 4 + 4 + 1 + 2 saturating non-bypassed lanes across the vectors.
    chk("sat_count_total", 64'(sat_count), 64'd11);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_count_clear", 64'(sat_count), 64'd0);
`endif

    // Backpressure: 8 beats, out_ready low for 5 cycles mid-stream.
    begin : bp
      logic [63:0] expq [$];
      logic [63:0] held;
      logic [63:0] xv;
      logic        stalled_prev;
      int          sent;
      int          got;
      sent = 0;
      got = 0;
      held = '0;
      stalled_prev = 1'b0;
      bus.in_func   = 2'd0;
      bus.in_bypass = 4'b0000;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
        xv = {4{16'h0500 + 16'(sent) * 16'h0010}};
        bus.in_valid  = (sent < 8);
        bus.in_data   = xv;
        bus.out_ready = !(cyc >= 4 && cyc <= 8);
        #1;
        if (stalled_prev) chk("bp_hold", bus.out_data, held);
        if (bus.out_valid && !bus.out_ready) begin
          chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
          held = bus.out_data;
          stalled_prev = 1'b1;
        end else begin
          stalled_prev = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) chk("bp_extra_out", 64'(bus.out_valid), 64'd0);
          else chk($sformatf("bp_data%0d", got), bus.out_data, expq.pop_front());
          got++;
        end
        if (bus.in_valid && bus.in_ready) begin
          expq.push_back(xv);
          sent++;
        end
        step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_count", 64'(got), 64'd8);
      repeat (4) step();
      chk("bp_drained", 64'(bus.out_valid), 64'd0);
    end

    // Reset with three beats in flight.
    bus.in_func   = 2'd0;
    bus.in_bypass = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{16'h0600 + 16'(k) * 16'h0010}};
      step();
    end
    bus.in_valid = 1'b0;
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("rst_data_clear", bus.out_data, 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_no_stale%0d", k), 64'(bus.out_valid), 64'd0);
      step();
    end
    run_one(2'd0, 4'b0000, {4{16'h0700}}, y, lat);
    chk("rst_new_latency", 64'(lat), 64'd3);
    chk("rst_new_data", y, {4{16'h0700}});

    // LUT write collision on table 0, segment 0x20 (x in 0x0000..0x03FF).
    bus.in_valid  = 1'b1;
    bus.in_func   = 2'd0;
    bus.in_bypass = 4'b0000;
    bus.in_data   = {4{16'h0200}};
    begin
      lut_entry_t e;
      e.a = 16'h2000;
      e.b = 16'h0000;
      lut_we    = 1'b1;
      lut_waddr = {2'd0, 6'h20};
      lut_wdata = e;
    end
    step();
    lut_we = 1'b0;
    step();
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("col_latency", 64'(n + 2), 64'd3);
    chk("col_old_coeff", bus.out_data, {4{16'h0200}});
    step();
    chk("col_new_valid", 64'(bus.out_valid), 64'd1);
    chk("col_new_coeff", bus.out_data, {4{16'h0400}});
    step();
    run_one(2'd0, 4'b0000, {4{16'h0400}}, y, lat);
    chk("col_neighbour_seg", y, {4{16'h0400}});
    run_one(2'd0, 4'b0000, {4{16'h8200}}, y, lat);
    chk("col_negative_seg", y, {4{16'h8200}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_pwl_unit.md
Name: act_pwl_unit

Overview:
- Multi-lane piecewise-linear activation unit. Computes y = A[seg]*x + B[seg] per lane.
- Coefficients come from a runtime-loadable LUT holding FUNC_COUNT function tables.
- Sits between the neuron-unit accumulators and XY memory write-back.
- Generalises the fixed Q4.12 / 4-lane / single-table activation: lane count, formats, table count and per-lane bypass are all parametrised, with valid/ready backpressure.

Parameters:
- LANES, 4 (NU_COUNT): parallel lanes.
- Q_INT, 4: integer bits of x and y.
- Q_FRAC, 12: fraction bits of x and y; Q_SIZE = Q_INT + Q_FRAC.
- LUT_DEPTH, 6: segment index bits; 2^LUT_DEPTH segments per table.
- FUNC_COUNT, 4: number of tables; FSEL_W = clog2(FUNC_COUNT), minimum 1.
- A_INT / A_FRAC, 4 / 12: slope format, signed.
- B_INT / B_FRAC, 4 / 12: intercept format, signed. B_FRAC <= Q_FRAC is mandatory.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  LANES*Q_SIZE  signed x per lane; lane i occupies [i*Q_SIZE +: Q_SIZE].
- in_func  in  FSEL_W  table select for the beat.
- in_bypass  in  LANES  per-lane bypass; when set, y = x.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*Q_SIZE  saturated y per lane.
- lut_we  in  1  coefficient write strobe.
- lut_waddr  in  FSEL_W+LUT_DEPTH  {func, seg}.
- lut_wdata  in  A_INT+A_FRAC+B_INT+B_FRAC  {A, B}; A in the upper field.

Behaviour:
- Reset:
  - out_valid = 0 and out_data = 0.
  - All stage valids and registers cleared; in_ready = 1 once rst deasserts.
  - LUT contents are not reset.
  - Reset asserted mid-operation drops all in-flight beats. No partial output is produced.
- Pipeline: 3 stages, S0 (LUT read), S1 (multiply), S2 (add/saturate/out register).
  - Latency is 3 cycles from the in handshake to out_valid, when not stalled.
  - Throughput is 1 beat/cycle.
- Handshake:
  - Global advance = !out_valid || out_ready.
  - in_ready = advance, computed combinationally; no bubble is required.
  - Beat accepted on in_valid && in_ready.
  - While out_valid && !out_ready: out_data is held stable, no stage advances, nothing is lost or duplicated.
- Segment index:
  - seg = {~x[Q_SIZE-1], x[Q_SIZE-2 -: LUT_DEPTH-1]} (offset binary).
  - Segment 0 is the most negative range.
  - LUT address = {in_func, seg}.
- LUT:
  - One synchronous-read copy per lane; writes broadcast to all copies.
  - Same-address write and read in the same cycle returns the old data (read-first).
  - Writes are permitted at any time, independent of the handshake.
  - A write to an address used by a beat already past S0 does not affect that beat.
- Arithmetic:
  - prod = A*x, full width (A_INT+A_FRAC+Q_SIZE bits).
  - Arithmetic shift right by A_FRAC (floor).
  - Add B << (Q_FRAC-B_FRAC), sign-extended, in a width with at least 2 guard bits.
  - Saturate to signed Q_SIZE: above max gives 0x7FFF; below min gives 0x8000 (16-bit case).
- Bypass: the lane outputs x unchanged, delayed to the same latency; the LUT is ignored for that lane.
- in_func and in_bypass are sampled with the beat and carried through the pipeline.

Optional Feature:
- Macro: ACT_PWL_SAT_CNT_EN.
- When defined:
  - Adds output port sat_count (32 bits).
  - sat_count increments by the number of non-bypassed lanes saturating on each out handshake.
  - Saturates at 0xFFFFFFFF; cleared by rst.
  - Adds input sat_clr (1 bit), synchronous clear; clear has priority over increment in the same cycle.
- When not defined: neither port exists and no counter logic is present.

Decomposition:
- Shared package (extend the project definitions package) holds:
  - the lut entry struct typedef {a, b};
  - LUT address width and FSEL_W localparams;
  - saturation min/max constants derived from Q_SIZE.
- One sub-module: act_pwl_lane, a single-lane LUT copy plus multiply/add/saturate datapath. It is instantiated LANES times.
- The handshake/stall control stays in the top.

Test Plan:
- Identity: load table 0 with A=0x1000, B=0 for all segs; x=0x1800 on all lanes -> out 0x1800 exactly 3 cycles later.
- Saturation: table 0 A=0x4000, B=0; x=0x7000 -> 0x7FFF; x=0x9000 -> 0x8000. With ACT_PWL_SAT_CNT_EN, sat_count increments by 4 per beat.
- Function select / bypass: table 1 A=0, B=0x0800; in_func=1, in_bypass=4'b0101, x=0x2000 -> lanes 0 and 2 give 0x2000, lanes 1 and 3 give 0x0800.
- Backpressure: stream 8 beats, hold out_ready low for 5 cycles mid-stream -> in_ready low while stalled, out_data stable, all 8 results in order with none lost or duplicated.
- LUT write collision: write seg 0x20 of table 0 in the same cycle a beat reads it -> that beat uses the old coefficients; the next beat uses the new ones.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid = 0 immediately; after release, no stale outputs and the first new beat emerges after 3 cycles.
